// File: rtl/axis_tx_pkt_arbiter.sv
// axis_tx_pkt_arbiter: packet-level round-robin arbiter sharing the MAC tx AXI-stream between two sources,
// with a length watchdog that truncates runaway packets and drains their remainder.
module axis_tx_pkt_arbiter #(
    parameter int MAX_WORDS = 384
) (
    input  logic        Clk_user,
    input  logic        Reset,
    input  logic        CPU_init_end,
    input  logic        s0_tvalid,
    input  logic [31:0] s0_tdata,
    input  logic [3:0]  s0_tstrb,
    input  logic        s0_tlast,
    output logic        s0_tready,
    input  logic        s1_tvalid,
    input  logic [31:0] s1_tdata,
    input  logic [3:0]  s1_tstrb,
    input  logic        s1_tlast,
    output logic        s1_tready,
    output logic        tx_tvalid,
    output logic [31:0] tx_tdata,
    output logic [3:0]  tx_tstrb,
    output logic        tx_tlast,
    input  logic        tx_tready,
    output logic [15:0] pkt_cnt0,
    output logic [15:0] pkt_cnt1,
    output logic [7:0]  trunc_cnt
);
    typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;
    state_t      state;
    logic        gnt, last_gnt, win;
    logic [15:0] word_cnt;
    logic        g_tvalid, g_tlast, g_tready, at_max, beat_ok;
    logic [31:0] g_tdata;
    logic [3:0]  g_tstrb;

    always_comb begin
        g_tvalid  = gnt ? s1_tvalid : s0_tvalid;
        g_tdata   = gnt ? s1_tdata : s0_tdata;
        g_tstrb   = gnt ? s1_tstrb : s0_tstrb;
        g_tlast   = gnt ? s1_tlast : s0_tlast;
        at_max    = word_cnt == 16'(MAX_WORDS - 1);
        win       = (s0_tvalid && s1_tvalid) ? !last_gnt : s1_tvalid;
        // DRAIN swallows the remainder of a truncated packet, so the source is always ready there
        g_tready  = state == SEND ? tx_tready : state == DRAIN;
        s0_tready = g_tready && !gnt;
        s1_tready = g_tready && gnt;
        tx_tvalid = state == SEND && g_tvalid;
        tx_tdata  = state == SEND ? g_tdata : '0;
        tx_tstrb  = state == SEND ? g_tstrb : '0;
        tx_tlast  = state == SEND && (g_tlast || at_max);
        beat_ok   = g_tvalid && g_tready;
    end

    always_ff @(posedge Clk_user or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            last_gnt  <= 1'b1;
            word_cnt  <= '0;
            pkt_cnt0  <= '0;
            pkt_cnt1  <= '0;
            trunc_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (CPU_init_end && (s0_tvalid || s1_tvalid)) begin
                    gnt      <= win;
                    last_gnt <= win;
                    word_cnt <= '0;
                    state    <= SEND;
                end
                SEND: if (beat_ok) begin
                    word_cnt <= word_cnt + 16'd1;
                    if (g_tlast || at_max) begin
                        if (gnt) pkt_cnt1 <= pkt_cnt1 + 16'd1;
                        else pkt_cnt0 <= pkt_cnt0 + 16'd1;
                        if (!g_tlast && trunc_cnt != 8'hFF) trunc_cnt <= trunc_cnt + 8'd1;
                        state <= g_tlast ? IDLE : DRAIN;
                    end
                end
                DRAIN: if (beat_ok && g_tlast) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_tx_pkt_arbiter.sv
// tb_axis_tx_pkt_arbiter: randomized packet traffic on both sources, checked against a packet-level
// model of round-robin order, truncation at MAX_WORDS and the packet/truncation counters.
module tb_axis_tx_pkt_arbiter;
    localparam int MW = 8;

    logic        Clk_user = 0, Reset = 1, CPU_init_end = 0;
    logic        s0_tvalid = 0, s0_tlast = 0, s1_tvalid = 0, s1_tlast = 0, tx_tready = 0;
    logic [31:0] s0_tdata = 0, s1_tdata = 0;
    logic [3:0]  s0_tstrb = 0, s1_tstrb = 0;
    logic        s0_tready, s1_tready, tx_tvalid, tx_tlast;
    logic [31:0] tx_tdata;
    logic [3:0]  tx_tstrb;
    logic [15:0] pkt_cnt0, pkt_cnt1;
    logic [7:0]  trunc_cnt;

    axis_tx_pkt_arbiter #(.MAX_WORDS(MW)) dut (
        .Clk_user(Clk_user), .Reset(Reset), .CPU_init_end(CPU_init_end),
        .s0_tvalid(s0_tvalid), .s0_tdata(s0_tdata), .s0_tstrb(s0_tstrb), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
        .s1_tvalid(s1_tvalid), .s1_tdata(s1_tdata), .s1_tstrb(s1_tstrb), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
        .tx_tvalid(tx_tvalid), .tx_tdata(tx_tdata), .tx_tstrb(tx_tstrb), .tx_tlast(tx_tlast), .tx_tready(tx_tready),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .trunc_cnt(trunc_cnt)
    );

    always #5 Clk_user = ~Clk_user;

    typedef struct packed {logic [31:0] d; logic [3:0] s; logic l; logic src;} beat_t;
    beat_t q0[$], q1[$], all0[$], all1[$], tx_log[$], pb;
    int    len0[$], len1[$];
    int    errors = 0, checks = 0, cyc = 0, first_fire, last_fire, disc, gap_pct, rdy_mode;
    logic  v0, v1, sop0, sop1, pv, pr;

    task automatic clear_tb();
        q0.delete(); q1.delete(); all0.delete(); all1.delete(); tx_log.delete();
        len0.delete(); len1.delete();
        v0 = 0; v1 = 0; sop0 = 1; sop1 = 1; pv = 0; pr = 0;
        disc = 0; first_fire = -1; last_fire = -1; gap_pct = 0; rdy_mode = 0;
        s0_tvalid = 0; s1_tvalid = 0; s0_tlast = 0; s1_tlast = 0; tx_tready = 0;
    endtask

    task automatic do_reset();
        Reset = 1;
        CPU_init_end = 0;
        clear_tb();
        repeat (2) @(negedge Clk_user);
        Reset = 0;
    endtask

    task automatic add_pkt(input int src, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.d = $urandom;
            b.s = 4'($urandom);
            b.l = (k == len - 1);
            b.src = 1'(src);
            if (src == 1) begin q1.push_back(b); all1.push_back(b); end
            else begin q0.push_back(b); all0.push_back(b); end
        end
        if (src == 1) len1.push_back(len); else len0.push_back(len);
    endtask

    // One clock: drive sources/MAC at negedge, sample 1ns later, book the handshakes of the coming posedge
    task automatic cycle();
        beat_t t;
        @(negedge Clk_user);
        if (!v0 && q0.size() > 0) v0 = sop0 || ($urandom_range(99) >= gap_pct);
        if (!v1 && q1.size() > 0) v1 = sop1 || ($urandom_range(99) >= gap_pct);
        s0_tvalid = v0; s1_tvalid = v1;
        if (v0) begin s0_tdata = q0[0].d; s0_tstrb = q0[0].s; s0_tlast = q0[0].l; end
        else begin s0_tdata = $urandom; s0_tstrb = 4'($urandom); s0_tlast = 0; end
        if (v1) begin s1_tdata = q1[0].d; s1_tstrb = q1[0].s; s1_tlast = q1[0].l; end
        else begin s1_tdata = $urandom; s1_tstrb = 4'($urandom); s1_tlast = 0; end
        if (rdy_mode == 0) tx_tready = 1;
        else if (rdy_mode == 1) tx_tready = (cyc % 2 == 0);
        else tx_tready = ($urandom_range(99) < 70);
        #1;
        checks++;
        if ((s0_tready && s1_tready) || (tx_tvalid && ((s0_tready || s1_tready) !== tx_tready)) ||
            (pv && !pr && !(tx_tvalid && tx_tdata === pb.d && tx_tstrb === pb.s && tx_tlast === pb.l))) begin
            errors++;
            $display("FAIL cycle_invariant cyc=%0d: tx_tvalid=%b tx_tready=%b s0_tready=%b s1_tready=%b tx_tdata=%h, required one ready mirroring tx_tready and held beat %h",
                     cyc, tx_tvalid, tx_tready, s0_tready, s1_tready, tx_tdata, pb.d);
        end
        pv = tx_tvalid; pr = tx_tready;
        pb.d = tx_tdata; pb.s = tx_tstrb; pb.l = tx_tlast; pb.src = 0;
        if (tx_tvalid && tx_tready) begin
            t.d = tx_tdata; t.s = tx_tstrb; t.l = tx_tlast; t.src = s1_tready;
            tx_log.push_back(t);
            if (first_fire < 0) first_fire = cyc;
            last_fire = cyc;
        end
        if (s0_tvalid && s0_tready) begin sop0 = q0[0].l; void'(q0.pop_front()); v0 = 0; if (!tx_tvalid) disc++; end
        if (s1_tvalid && s1_tready) begin sop1 = q1[0].l; void'(q1.pop_front()); v1 = 0; if (!tx_tvalid) disc++; end
        cyc++;
    endtask

    task automatic run(input int budget, input string name);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin cycle(); n++; end
        checks++;
        if (q0.size() > 0 || q1.size() > 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d beats left after %0d cycles, required 0", name, q0.size() + q1.size(), n);
        end
        repeat (2) cycle();
    endtask

    // Packet-level model: alternate while both have packets, lone requester back-to-back,
    // each packet cut to MW beats with tlast on the final delivered beat.
    task automatic check_stream(input string name);
        beat_t exp_q[$];
        beat_t b;
        int i0 = 0, i1 = 0, o0 = 0, o1 = 0, last = 1, e_p0 = 0, e_p1 = 0, e_tr = 0, e_disc = 0, s, len, n, m;
        while (i0 < len0.size() || i1 < len1.size()) begin
            s = (i0 < len0.size() && i1 < len1.size()) ? 1 - last : (i0 < len0.size() ? 0 : 1);
            last = s;
            len = s == 1 ? len1[i1] : len0[i0];
            n = len > MW ? MW : len;
            for (int k = 0; k < n; k++) begin
                b = s == 1 ? all1[o1 + k] : all0[o0 + k];
                b.l = (k == n - 1);
                exp_q.push_back(b);
            end
            if (len > MW) begin e_tr++; e_disc += len - MW; end
            if (s == 1) begin e_p1++; i1++; o1 += len; end
            else begin e_p0++; i0++; o0 += len; end
        end
        checks++;
        if (tx_log.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_beat_count: got %0d tx beats, required %0d", name, tx_log.size(), exp_q.size());
        end
        m = tx_log.size() < exp_q.size() ? tx_log.size() : exp_q.size();
        for (int k = 0; k < m; k++) begin
            checks++;
            if (tx_log[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL %s_beat[%0d]: got src=%0d data=%h strb=%h last=%b, required src=%0d data=%h strb=%h last=%b",
                         name, k, tx_log[k].src, tx_log[k].d, tx_log[k].s, tx_log[k].l,
                         exp_q[k].src, exp_q[k].d, exp_q[k].s, exp_q[k].l);
            end
        end
        checks++;
        if (pkt_cnt0 !== 16'(e_p0)) begin errors++; $display("FAIL %s_pkt_cnt0: got %0d, required %0d", name, pkt_cnt0, e_p0); end
        checks++;
        if (pkt_cnt1 !== 16'(e_p1)) begin errors++; $display("FAIL %s_pkt_cnt1: got %0d, required %0d", name, pkt_cnt1, e_p1); end
        checks++;
        if (trunc_cnt !== 8'(e_tr > 255 ? 255 : e_tr)) begin
            errors++; $display("FAIL %s_trunc_cnt: got %0d, required %0d", name, trunc_cnt, e_tr > 255 ? 255 : e_tr);
        end
        checks++;
        if (disc != e_disc) begin errors++; $display("FAIL %s_drained: got %0d beats, required %0d", name, disc, e_disc); end
    endtask

    task automatic test_reset();
        Reset = 1; CPU_init_end = 1; s0_tvalid = 1; s1_tvalid = 1; tx_tready = 1; s0_tdata = $urandom;
        #3;
        checks++;
        if ({tx_tvalid, tx_tdata, tx_tstrb, tx_tlast, s0_tready, s1_tready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_held: tx_tvalid=%b tx_tdata=%h s0_tready=%b s1_tready=%b, required all 0", tx_tvalid, tx_tdata, s0_tready, s1_tready);
        end
        do_reset();
        #1;
        checks++;
        if ({tx_tvalid, tx_tdata, tx_tstrb, tx_tlast, s0_tready, s1_tready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: tx_tvalid=%b tx_tdata=%h tx_tlast=%b, required all 0", tx_tvalid, tx_tdata, tx_tlast);
        end
        checks++;
        if ({pkt_cnt0, pkt_cnt1, trunc_cnt} !== '0) begin
            errors++; $display("FAIL reset_counters: got %h/%h/%h, required 0/0/0", pkt_cnt0, pkt_cnt1, trunc_cnt);
        end
    endtask

    task automatic test_init_gate();
        do_reset();
        add_pkt(0, 4); add_pkt(1, 4);
        for (int i = 0; i < 20; i++) begin
            cycle();
            checks++;
            if (tx_tvalid !== 0 || s0_tready !== 0 || s1_tready !== 0) begin
                errors++;
                $display("FAIL init_gate cyc=%0d: tx_tvalid=%b s0_tready=%b s1_tready=%b, required 0", i, tx_tvalid, s0_tready, s1_tready);
            end
        end
        CPU_init_end = 1;
        cycle();
        checks++;
        if (tx_tvalid !== 1 || tx_tdata !== all0[0].d || s0_tready !== 1) begin
            errors++;
            $display("FAIL init_first_beat: tx_tvalid=%b tx_tdata=%h s0_tready=%b, required 1 %h 1", tx_tvalid, tx_tdata, s0_tready, all0[0].d);
        end
        run(100, "init");
        check_stream("init");
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 5; i++) begin add_pkt(0, 4); add_pkt(1, 4); end
        CPU_init_end = 1;
        run(200, "rr");
        check_stream("rr");
        checks++;
        if (last_fire - first_fire + 1 != 49) begin
            errors++; $display("FAIL rr_span: got %0d cycles first to last beat, required 49", last_fire - first_fire + 1);
        end
    endtask

    task automatic test_stall();
        do_reset();
        add_pkt(1, 6);
        rdy_mode = 1;
        CPU_init_end = 1;
        run(100, "stall");
        check_stream("stall");
    endtask

    task automatic test_truncate();
        do_reset();
        add_pkt(0, 12);
        CPU_init_end = 1;
        run(100, "trunc");
        check_stream("trunc");
        checks++;
        if (s0_tready !== 0 || s1_tready !== 0 || tx_tvalid !== 0) begin
            errors++;
            $display("FAIL trunc_back_to_idle: s0_tready=%b s1_tready=%b tx_tvalid=%b, required 0 0 0", s0_tready, s1_tready, tx_tvalid);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0, lasts = 0;
        do_reset();
        add_pkt(0, 2); add_pkt(0, 10);
        CPU_init_end = 1;
        while (tx_log.size() < 4 && n < 50) begin cycle(); n++; end
        checks++;
        if (tx_log.size() < 4) begin errors++; $display("FAIL rmid_timeout: got %0d tx beats, required 4", tx_log.size()); end
        @(posedge Clk_user);
        #2 Reset = 1;
        #1;
        checks++;
        if ({tx_tvalid, tx_tdata, tx_tstrb, tx_tlast, s0_tready, s1_tready} !== '0 || {pkt_cnt0, pkt_cnt1, trunc_cnt} !== '0) begin
            errors++;
            $display("FAIL rmid_async: tx_tvalid=%b tx_tlast=%b s0_tready=%b pkt_cnt0=%0d, required all 0", tx_tvalid, tx_tlast, s0_tready, pkt_cnt0);
        end
        foreach (tx_log[k]) if (tx_log[k].l) lasts++;
        checks++;
        if (lasts != 1) begin errors++; $display("FAIL rmid_no_tlast: got %0d tlast beats, required 1", lasts); end
        @(negedge Clk_user);
        CPU_init_end = 0;
        clear_tb();
        @(negedge Clk_user);
        Reset = 0;
        add_pkt(0, 3); add_pkt(1, 3);
        CPU_init_end = 1;
        run(100, "rmid");
        check_stream("rmid");
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 8; i++) add_pkt(0, $urandom_range(1, 12));
        for (int i = 0; i < 6; i++) add_pkt(1, $urandom_range(1, 12));
        gap_pct = 30;
        rdy_mode = 2;
        CPU_init_end = 1;
        run(3000, "rand");
        check_stream("rand");
    endtask

    task automatic test_trunc_sat();
        do_reset();
        for (int i = 0; i < 260; i++) add_pkt(0, 9);
        CPU_init_end = 1;
        run(6000, "sat");
        check_stream("sat");
    endtask

    initial begin
        test_reset();
        test_init_gate();
        test_round_robin();
        test_stall();
        test_truncate();
        test_reset_mid();
        test_random();
        test_trunc_sat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
